// File: rtl/madd_msub_unit.sv
// Purpose : EX-stage sequencer for MADD/MADDU/MSUB/MSUBU, {HI,LO} +/- (opdata1 * opdata2).
// Latency : start accepted in cycle 0, whilo/hilo_o presented in cycle 3; stallreq high cycles 0-2.
// Backpr. : DONE holds its result while stall[3] is set; flush aborts from any state.
// Ports   : clk/rst (async active-high) | flush, stall[5:0] pipeline control |
//           start, op, opdata1, opdata2, hi_i, lo_i request side |
//           stallreq, hilo_o, whilo, busy result side toward EX/MEM.
module madd_msub_unit #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [5:0]      stall,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [DW-1:0]   opdata1,
  input  logic [DW-1:0]   opdata2,
  input  logic [DW-1:0]   hi_i,
  input  logic [DW-1:0]   lo_i,
  output logic            stallreq,
  output logic [2*DW-1:0] hilo_o,
  output logic            whilo,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;       // op[0]=1: unsigned, op[1]=1: subtract
  logic [DW-1:0]     opa_q, opa_d;
  logic [DW-1:0]     opb_q, opb_d;
  logic [2*DW-1:0]   hilo_q, hilo_d;
  logic [2*DW-1:0]   prod_q, prod_d;
  logic [2*DW-1:0]   res_q, res_d;
  logic [2*DW-1:0]   ext_a, ext_b, mul_full;

  // Only the EX/MEM hold bit matters to this block.
  logic unused_stall;
  assign unused_stall = ^{stall[5:4], stall[2:0]};

  // Extending both operands to 2*DW and keeping the low 2*DW bits of the
  // product gives the exact signed or unsigned result, so one multiplier
  // serves all four opcodes.
  always_comb begin
    ext_a    = {{DW{opa_q[DW-1] & ~op_q[0]}}, opa_q};
    ext_b    = {{DW{opb_q[DW-1] & ~op_q[0]}}, opb_q};
    mul_full = ext_a * ext_b;
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hilo_d   = hilo_q;
    prod_d   = prod_q;
    res_d    = res_q;
    stallreq = 1'b0;
    whilo    = 1'b0;
    hilo_o   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          stallreq = 1'b1;
          state_d  = MUL;
          op_d     = op;
          opa_d    = opdata1;
          opb_d    = opdata2;
          hilo_d   = {hi_i, lo_i};
        end
      end
      MUL: begin
        stallreq = 1'b1;
        prod_d   = mul_full;
        state_d  = ACC;
      end
      ACC: begin
        stallreq = 1'b1;
        res_d    = op_q[1] ? (hilo_q - prod_q) : (hilo_q + prod_q);
        state_d  = DONE;
      end
      DONE: begin
        whilo  = 1'b1;
        hilo_o = res_q;
        // start is deliberately not looked at here, so one instruction
        // is accumulated exactly once.
        if (!stall[3]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush kills whatever is in flight, including a pending write in DONE.
    if (flush) begin
      stallreq = 1'b0;
      whilo    = 1'b0;
      hilo_o   = '0;
      state_d  = IDLE;
      res_d    = '0;
    end

    // Keep the stall request quiet while reset is held, even if start is up.
    if (rst) begin
      stallreq = 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      hilo_q  <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      hilo_q  <= hilo_d;
      prod_q  <= prod_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_madd_msub_unit.sv
module tb_madd_msub_unit;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [5:0]  stall;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opdata1, opdata2, hi_i, lo_i;
  logic        stallreq;
  logic [63:0] hilo_o;
  logic        whilo;
  logic        busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] exp_q[$];

  madd_msub_unit #(.DW(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .stall    (stall),
    .start    (start),
    .op       (op),
    .opdata1  (opdata1),
    .opdata2  (opdata2),
    .hi_i     (hi_i),
    .lo_i     (lo_i),
    .stallreq (stallreq),
    .hilo_o   (hilo_o),
    .whilo    (whilo),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk1(string name, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  function automatic void chk64(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: compares the result whenever the DUT presents whilo. While
  // stall[3] holds DONE the head entry is checked again (stability); it is
  // retired on the cycle the result leaves.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (whilo) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_whilo: got whilo=1 hilo=%h expected no result", hilo_o);
        end else begin
          chk64("hilo_result", hilo_o, exp_q[0]);
          if (!stall[3]) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One full operation with cycle-by-cycle control checks. hold = number of
  // DONE cycles with stall[3] set; perturb changes the forwarded inputs after
  // acceptance; keep_start leaves start high until the unit is back in IDLE.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] h, input logic [31:0] l, input logic [63:0] exp,
                        input int hold, input bit keep_start, input bit perturb);
    @(negedge clk);
    op = o; opdata1 = a; opdata2 = b; hi_i = h; lo_i = l; start = 1'b1;
    exp_q.push_back(exp);
    #1;
    chk1("c0_stallreq", stallreq, 1'b1);
    chk1("c0_busy", busy, 1'b0);
    @(negedge clk);
    if (!keep_start) start = 1'b0;
    if (perturb) begin
      opdata1 = ~a; opdata2 = a ^ b; hi_i = ~h; lo_i = ~l; op = ~o;
    end
    #1;
    chk1("mul_stallreq", stallreq, 1'b1);
    chk1("mul_busy", busy, 1'b1);
    chk1("mul_whilo", whilo, 1'b0);
    @(negedge clk);
    if (perturb) begin
      opdata1 = 32'h1234_5678; hi_i = 32'hDEAD_BEEF;
    end
    #1;
    chk1("acc_stallreq", stallreq, 1'b1);
    chk1("acc_whilo", whilo, 1'b0);
    chk64("acc_hilo_zero", hilo_o, 64'h0);
    @(negedge clk);
    stall = (hold > 0) ? 6'b001000 : 6'b000000;
    #1;
    chk1("done_stallreq", stallreq, 1'b0);
    chk1("done_whilo", whilo, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (i == hold - 1) stall = 6'b000000;
      #1;
      chk1("hold_whilo", whilo, 1'b1);
      chk1("hold_busy", busy, 1'b1);
    end
    @(negedge clk);
    start = 1'b0;
    #1;
    chk1("idle_busy", busy, 1'b0);
    chk1("idle_whilo", whilo, 1'b0);
    chk64("idle_hilo_zero", hilo_o, 64'h0);
    @(negedge clk);
    #1;
    chk1("no_retrigger_busy", busy, 1'b0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall = '0; start = 1'b0; op = 2'b00;
    opdata1 = '0; opdata2 = '0; hi_i = '0; lo_i = '0;
    #12;
    chk1("rst_stallreq", stallreq, 1'b0);
    chk1("rst_whilo", whilo, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk64("rst_hilo", hilo_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // Basic signed MADD: 10 + 3*(-2) = 4
    run_op(2'b00, 32'd3, 32'hFFFF_FFFE, 32'h0, 32'hA, 64'h4, 0, 0, 0);
    // MADDU / MADD with all-ones operands
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'hFFFF_FFFE_0000_0001, 0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 64'h1, 0, 0, 0);
    // MSUBU wrap, MSUB
    run_op(2'b11, 32'd1, 32'd1, 32'h0, 32'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
    run_op(2'b10, 32'd2, 32'd3, 32'h0, 32'h10, 64'hA, 0, 0, 0);
    // Signed min * min = 2^62, plus 0xC000... wraps to zero
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0, 64'h0, 0, 0, 0);

    // Flush during ACC: no result, then a clean follow-up op
    @(negedge clk);
    op = 2'b00; opdata1 = 32'd5; opdata2 = 32'd5; hi_i = 32'h0; lo_i = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk1("flush_stallreq", stallreq, 1'b0);
    chk1("flush_whilo", whilo, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk1("post_flush_busy", busy, 1'b0);
    chk1("post_flush_whilo", whilo, 1'b0);
    @(negedge clk);
    #1;
    chk1("post_flush_whilo2", whilo, 1'b0);
    run_op(2'b00, 32'd1, 32'd1, 32'h0, 32'h0, 64'h1, 0, 0, 0);

    // DONE held two cycles by stall[3], start kept high throughout:
    // 0x10000*0x10000 + {1,2} = 0x0000000200000002
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h1, 32'h2, 64'h0000_0002_0000_0002, 2, 1, 0);

    // Async reset between edges during MUL
    @(negedge clk);
    op = 2'b00; opdata1 = 32'd9; opdata2 = 32'd9; hi_i = 32'h0; lo_i = 32'h0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    chk1("arst_stallreq", stallreq, 1'b0);
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_whilo", whilo, 1'b0);
    chk64("arst_hilo", hilo_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk1("post_arst_busy", busy, 1'b0);

    // Forwarded inputs change after acceptance: 100 - 7*(-3) ... MSUB: 100 - (-21)? no:
    // MSUB computes hilo - a*b = 100 - (7 * -3) = 121 = 0x79
    run_op(2'b10, 32'd7, 32'hFFFF_FFFD, 32'h0, 32'd100, 64'h79, 0, 0, 1);

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
